// File: rtl/cordic_pkg.sv
// Shared state encoding and constants for the CORDIC sequencer and its shift generator.
package cordic_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ITER,
        S_FINISH,
        S_DONE
    } state_t;

    // Hyperbolic CORDIC only converges if these shift indices are applied twice.
    localparam int HYP_REPEAT_0 = 4;
    localparam int HYP_REPEAT_1 = 13;
    localparam int HYP_REPEAT_2 = 40;

    // z is a binary angle: 2**p_WIDTH LSBs span this many degrees.
    localparam int ANGLE_FULL_TURN_DEG = 360;

    function automatic logic is_hyp_repeat(input int idx);
        return (idx == HYP_REPEAT_0) || (idx == HYP_REPEAT_1) || (idx == HYP_REPEAT_2);
    endfunction

endpackage

// File: rtl/cordic_controller_if.sv
// Command and result handshakes of the CORDIC sequencer; master issues commands, slave is the controller.
interface cordic_controller_if #(
    parameter int p_WIDTH  = 32,
    parameter int p_ITER_W = 6
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [p_WIDTH-1:0]  cmd_x;
    logic [p_WIDTH-1:0]  cmd_y;
    logic [p_WIDTH-1:0]  cmd_z;
    logic                cmd_system;
    logic                cmd_mode;
    logic [p_ITER_W-1:0] cmd_iter;

    logic                res_valid;
    logic                res_ready;
    logic [p_WIDTH-1:0]  res_x;
    logic [p_WIDTH-1:0]  res_y;
    logic [p_WIDTH-1:0]  res_z;
    logic                res_overflow;
    logic [p_ITER_W-1:0] res_iter_done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_z, cmd_system, cmd_mode, cmd_iter, res_ready,
        input  cmd_ready, res_valid, res_x, res_y, res_z, res_overflow, res_iter_done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_z, cmd_system, cmd_mode, cmd_iter, res_ready,
        output cmd_ready, res_valid, res_x, res_y, res_z, res_overflow, res_iter_done
    );

endinterface

// File: rtl/cordic_shift_gen.sv
// Shift-index generator: circular 0,1,2.. / hyperbolic 1,2,3,4,4,5..13,13.. saturating at p_WIDTH-1.
// Latency: clear/advance take effect on the next edge; shift is a registered output.
// Backpressure: none; advances only when the controller enables an iteration.
module cordic_shift_gen
    import cordic_pkg::*;
#(
    parameter int p_WIDTH   = 32,
    parameter int p_SHIFT_W = $clog2(p_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 advance,
    input  logic                 circular,
    output logic [p_SHIFT_W-1:0] shift
);

    localparam logic [p_SHIFT_W-1:0] SHIFT_MAX = p_SHIFT_W'(p_WIDTH - 1);

    logic [p_SHIFT_W-1:0] idx;
    logic                 repeated;
    logic                 hold_for_repeat;

    // A repeat index is issued once more before moving on; the flag marks the second issue.
    assign hold_for_repeat = !circular && !repeated && is_hyp_repeat(int'(idx));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            repeated <= 1'b0;
        end else if (clear) begin
            idx      <= circular ? '0 : p_SHIFT_W'(1);
            repeated <= 1'b0;
        end else if (advance) begin
            if (hold_for_repeat) begin
                repeated <= 1'b1;
            end else begin
                repeated <= 1'b0;
                if (idx != SHIFT_MAX) begin
                    idx <= idx + p_SHIFT_W'(1);
                end
            end
        end
    end

    assign shift = idx;

endmodule

// File: rtl/cordic_controller.sv
// Sequencer in front of the cordic core: latches a command, loads the core, issues one iteration per cycle.
// Latency: accept at edge 0 -> res_valid in cycle N+3 (N = clamped or overflow-truncated count).
// Backpressure: cmd_ready only in IDLE; result held in DONE until res_ready, then IDLE for one cycle.
module cordic_controller
    import cordic_pkg::*;
#(
    parameter int p_WIDTH    = 32,
    parameter int p_MAX_ITER = 32,
    parameter int p_ITER_W   = $clog2(p_MAX_ITER + 1),
    parameter int p_SHIFT_W  = $clog2(p_WIDTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    cordic_controller_if.slave   bus,
    output logic                 busy,
    output logic                 core_load,
    output logic [p_WIDTH-1:0]   core_x_init,
    output logic [p_WIDTH-1:0]   core_y_init,
    output logic [p_WIDTH-1:0]   core_z_init,
    output logic                 core_system,
    output logic                 core_mode,
    output logic                 core_enable,
    output logic [p_SHIFT_W-1:0] core_shift,
    input  logic [p_WIDTH-1:0]   core_x,
    input  logic [p_WIDTH-1:0]   core_y,
    input  logic [p_WIDTH-1:0]   core_z,
    input  logic                 core_overflow
);

    typedef struct packed {
        logic [p_WIDTH-1:0]  x;
        logic [p_WIDTH-1:0]  y;
        logic [p_WIDTH-1:0]  z;
        logic                system;
        logic                mode;
        logic [p_ITER_W-1:0] count;
    } cmd_t;

    localparam logic [p_ITER_W-1:0] MAX_COUNT = p_ITER_W'(p_MAX_ITER);

    state_t              state;
    state_t              state_nxt;
    cmd_t                cmd_q;
    logic [p_ITER_W-1:0] iter_cnt;
    logic [p_ITER_W-1:0] clamped_iter;
    logic                ovf_q;
    logic                last_iter;

    assign clamped_iter = (bus.cmd_iter > MAX_COUNT) ? MAX_COUNT : bus.cmd_iter;
    assign last_iter    = (iter_cnt + p_ITER_W'(1)) == cmd_q.count;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Core strobes are gated by rst so an abort stops the core in the reset cycle itself.
    always_comb begin
        state_nxt     = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        busy          = 1'b1;
        core_load     = 1'b0;
        core_enable   = 1'b0;
        case (state)
            S_IDLE: begin
                busy          = 1'b0;
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                core_load = !rst;
                state_nxt = (cmd_q.count != '0) ? S_ITER : S_FINISH;
            end
            S_ITER: begin
                core_enable = !rst;
                if (core_overflow || last_iter) begin
                    state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q             <= '0;
            iter_cnt          <= '0;
            ovf_q             <= 1'b0;
            bus.res_x         <= '0;
            bus.res_y         <= '0;
            bus.res_z         <= '0;
            bus.res_overflow  <= 1'b0;
            bus.res_iter_done <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd_q.x           <= bus.cmd_x;
                        cmd_q.y           <= bus.cmd_y;
                        cmd_q.z           <= bus.cmd_z;
                        cmd_q.system      <= bus.cmd_system;
                        cmd_q.mode        <= bus.cmd_mode;
                        cmd_q.count       <= clamped_iter;
                        iter_cnt          <= '0;
                        ovf_q             <= 1'b0;
                        bus.res_overflow  <= 1'b0;
                        bus.res_iter_done <= '0;
                    end
                end
                S_ITER: begin
                    iter_cnt <= iter_cnt + p_ITER_W'(1);
                    if (core_overflow) begin
                        ovf_q <= 1'b1;
                    end
                end
                S_FINISH: begin
                    bus.res_x         <= core_x;
                    bus.res_y         <= core_y;
                    bus.res_z         <= core_z;
                    bus.res_overflow  <= ovf_q;
                    bus.res_iter_done <= iter_cnt;
                end
                default: begin
                end
            endcase
        end
    end

    assign core_x_init = cmd_q.x;
    assign core_y_init = cmd_q.y;
    assign core_z_init = cmd_q.z;
    assign core_system = cmd_q.system;
    assign core_mode   = cmd_q.mode;

    cordic_shift_gen #(
        .p_WIDTH   (p_WIDTH),
        .p_SHIFT_W (p_SHIFT_W)
    ) u_shift_gen (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == S_LOAD),
        .advance  (core_enable),
        .circular (cmd_q.system),
        .shift    (core_shift)
    );

endmodule

// File: tb/tb_cordic_controller.sv
// Bench for cordic_controller: behavioural core model plus a list-based reference of shifts, latency and results.
module tb_cordic_controller;
    import cordic_pkg::*;

    localparam int W      = 32;
    localparam int MAXI   = 32;
    localparam int IW     = $clog2(MAXI + 1);
    localparam int SW     = $clog2(W);
    localparam int BUDGET = 200;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cordic_controller_if #(.p_WIDTH(W), .p_ITER_W(IW)) bus ();

    logic          busy, core_load, core_system, core_mode, core_enable, core_overflow;
    logic [W-1:0]  core_x_init, core_y_init, core_z_init, core_x, core_y, core_z;
    logic [SW-1:0] core_shift;

    cordic_controller #(.p_WIDTH(W), .p_MAX_ITER(MAXI), .p_ITER_W(IW), .p_SHIFT_W(SW)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy), .core_load(core_load),
        .core_x_init(core_x_init), .core_y_init(core_y_init), .core_z_init(core_z_init),
        .core_system(core_system), .core_mode(core_mode), .core_enable(core_enable),
        .core_shift(core_shift), .core_x(core_x), .core_y(core_y), .core_z(core_z),
        .core_overflow(core_overflow)
    );

    int errors = 0;
    int checks = 0;
    int atan_tab [0:W-1];
    vec_t core_v = '0;
    int en_cnt = 0;
    int ovf_at = 0;
    int obs_shift[$];
    int n_load = 0;
    int exp_q[$];
    int lat;
    logic [W-1:0] r_x, r_y, r_z;
    logic r_ovf;
    int r_done;

    function automatic vec_t cstep(input vec_t v, input logic circ, input logic rot, input int s);
        logic signed [W-1:0] vx, vy, vz, xs, ys;
        logic up;
        vec_t n;
        vx = v.x; vy = v.y; vz = v.z;
        xs = vx >>> s;
        ys = vy >>> s;
        up = rot ? (vz >= 0) : (vy < 0);
        n.y = up ? vy + xs : vy - xs;
        n.z = up ? vz - atan_tab[s] : vz + atan_tab[s];
        n.x = (up == circ) ? vx - ys : vx + ys;
        return n;
    endfunction

    // Core stand-in: registered x/y/z, overflow raised on a chosen enabled iteration.
    always @(posedge clk) begin
        if (core_load) begin
            core_v <= vec_t'({core_x_init, core_y_init, core_z_init});
            en_cnt <= 0;
        end else if (core_enable) begin
            core_v <= cstep(core_v, core_system, core_mode, int'(core_shift));
            en_cnt <= en_cnt + 1;
        end
    end
    assign core_x = core_v.x;
    assign core_y = core_v.y;
    assign core_z = core_v.z;
    assign core_overflow = core_enable && (ovf_at > 0) && (en_cnt + 1 == ovf_at);

    always @(negedge clk) begin
        if (core_enable) obs_shift.push_back(int'(core_shift));
        if (core_load) n_load <= n_load + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic init_tables();
        for (int i = 0; i < W; i++)
            atan_tab[i] = $rtoi($atan(2.0 ** (-i)) * 180.0 / 3.14159265358979 / ANGLE_FULL_TURN_DEG * (2.0 ** W));
    endtask

    // Reference: hyperbolic list 1,2,3,4,4,5,..13,13,.. ; circular 0,1,2,..; saturated at W-1.
    task automatic ref_run(input vec_t v0, input logic circ, input logic rot, input int n, input int ovf,
                           output vec_t v, output int n_eff);
        exp_q.delete();
        for (int k = circ ? 0 : 1; exp_q.size() < n; k++) begin
            exp_q.push_back(k > W - 1 ? W - 1 : k);
            if (!circ && (k == 4 || k == 13 || k == 40) && exp_q.size() < n)
                exp_q.push_back(k > W - 1 ? W - 1 : k);
        end
        n_eff = (ovf > 0 && ovf < n) ? ovf : n;
        v = v0;
        for (int i = 0; i < n_eff; i++) v = cstep(v, circ, rot, exp_q[i]);
    endtask

    task automatic start_cmd(input vec_t v0, input logic circ, input logic rot, input int iter,
                             output int sh0, output int ld0);
        int waited;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_x = v0.x; bus.cmd_y = v0.y; bus.cmd_z = v0.z;
        bus.cmd_system = circ; bus.cmd_mode = rot; bus.cmd_iter = IW'(iter);
        waited = 0;
        while (!bus.cmd_ready && waited < BUDGET) begin @(negedge clk); waited++; end
        checks++;
        if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL accept_timeout: cmd_ready=%b want 1", bus.cmd_ready); end
        @(posedge clk);
        sh0 = obs_shift.size();
        ld0 = n_load;
        lat = 0;
        do begin @(negedge clk); bus.cmd_valid = 1'b0; lat++; end while (!bus.res_valid && lat < BUDGET);
        checks++;
        if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL result_timeout: res_valid=%b want 1", bus.res_valid); end
        r_x = bus.res_x; r_y = bus.res_y; r_z = bus.res_z; r_ovf = bus.res_overflow; r_done = int'(bus.res_iter_done);
    endtask

    task automatic consume();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; bus.cmd_valid = 1'b0; bus.res_ready = 1'b0; bus.cmd_x = '0; bus.cmd_y = '0;
        bus.cmd_z = '0; bus.cmd_system = 1'b0; bus.cmd_mode = 1'b0; bus.cmd_iter = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        checks++; if ({bus.res_valid, busy, core_load, core_enable, core_system, core_mode, bus.res_overflow} !== '0) begin
            errors++; $display("FAIL reset_flags: got %b want 0", {bus.res_valid, busy, core_load, core_enable, core_system, core_mode, bus.res_overflow}); end
        checks++; if ({core_shift, bus.res_iter_done} !== '0) begin
            errors++; $display("FAIL reset_counts: shift=%0d iter_done=%0d want 0", core_shift, bus.res_iter_done); end
        checks++; if ({core_x_init, core_y_init, core_z_init, bus.res_x, bus.res_y, bus.res_z} !== '0) begin
            errors++; $display("FAIL reset_data: init/res not all zero (res_x=%h)", bus.res_x); end
    endtask

    task automatic test_circular_rotation();
        vec_t v0, ev; int sh0, ld0, ne; longint d;
        v0.x = 32'sh4DBA76D4; v0.y = '0; v0.z = 32'sh20000000; ovf_at = 0;
        start_cmd(v0, 1'b1, 1'b1, 10, sh0, ld0);
        ref_run(v0, 1'b1, 1'b1, 10, 0, ev, ne);
        checks++; if (lat != 13) begin errors++; $display("FAIL circ_latency: got %0d want 13", lat); end
        d = longint'($signed(r_x)) - longint'(32'sh5A82799A);
        checks++; if (d > (64'sd1 <<< 22) || d < -(64'sd1 <<< 22)) begin errors++; $display("FAIL circ_x: got %h want ~5a82799a", r_x); end
        d = longint'($signed(r_y)) - longint'(32'sh5A82799A);
        checks++; if (d > (64'sd1 <<< 22) || d < -(64'sd1 <<< 22)) begin errors++; $display("FAIL circ_y: got %h want ~5a82799a", r_y); end
        d = longint'($signed(r_z));
        checks++; if (d > 1431655 || d < -1431655) begin errors++; $display("FAIL circ_z: got %h want ~0", r_z); end
        checks++; if (r_ovf !== 1'b0) begin errors++; $display("FAIL circ_ovf: got %b want 0", r_ovf); end
        checks++; if (r_done != 10) begin errors++; $display("FAIL circ_iter_done: got %0d want 10", r_done); end
        checks++; if ({r_x, r_y, r_z} !== ev) begin errors++; $display("FAIL circ_ref: got %h want %h", {r_x, r_y, r_z}, ev); end
        consume();
    endtask

    task automatic test_shift_seq();
        int hyp_exp[16] = '{1, 2, 3, 4, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 13, 14};
        vec_t v0; int sh0, ld0;
        v0.x = 32'sh20000000; v0.y = 32'sh08000000; v0.z = 32'sh01000000; ovf_at = 0;
        start_cmd(v0, 1'b0, 1'b1, 16, sh0, ld0);
        checks++; if (obs_shift.size() - sh0 != 16) begin errors++; $display("FAIL hyp_count: got %0d want 16", obs_shift.size() - sh0); end
        for (int i = 0; i < 16 && sh0 + i < obs_shift.size(); i++) begin
            checks++; if (obs_shift[sh0 + i] != hyp_exp[i]) begin errors++; $display("FAIL hyp_shift[%0d]: got %0d want %0d", i, obs_shift[sh0 + i], hyp_exp[i]); end
        end
        consume();
        start_cmd(v0, 1'b1, 1'b0, 5, sh0, ld0);
        checks++; if (obs_shift.size() - sh0 != 5) begin errors++; $display("FAIL circ_count: got %0d want 5", obs_shift.size() - sh0); end
        for (int i = 0; i < 5 && sh0 + i < obs_shift.size(); i++) begin
            checks++; if (obs_shift[sh0 + i] != i) begin errors++; $display("FAIL circ_shift[%0d]: got %0d want %0d", i, obs_shift[sh0 + i], i); end
        end
        consume();
    endtask

    task automatic test_overflow();
        vec_t v0; int sh0, ld0;
        v0.x = 32'sh10000000; v0.y = 32'sh04000000; v0.z = 32'sh00400000; ovf_at = 3;
        start_cmd(v0, 1'b1, 1'b1, 10, sh0, ld0);
        checks++; if (obs_shift.size() - sh0 != 3) begin errors++; $display("FAIL ovf_iter_cycles: got %0d want 3", obs_shift.size() - sh0); end
        checks++; if (r_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", r_ovf); end
        checks++; if (r_done != 3) begin errors++; $display("FAIL ovf_iter_done: got %0d want 3", r_done); end
        checks++; if (lat != 6) begin errors++; $display("FAIL ovf_latency: got %0d want 6", lat); end
        consume();
        ovf_at = 0;
    endtask

    task automatic test_zero_and_clamp();
        vec_t v0, ev; int sh0, ld0, ne;
        v0.x = 32'sh12345678; v0.y = -32'sh0ABCDEF0; v0.z = 32'sh7F00FF00; ovf_at = 0;
        start_cmd(v0, 1'b1, 1'b1, 0, sh0, ld0);
        checks++; if (n_load - ld0 != 1) begin errors++; $display("FAIL zero_loads: got %0d want 1", n_load - ld0); end
        checks++; if (obs_shift.size() - sh0 != 0) begin errors++; $display("FAIL zero_enables: got %0d want 0", obs_shift.size() - sh0); end
        checks++; if ({r_x, r_y, r_z} !== v0) begin errors++; $display("FAIL zero_result: got %h want %h", {r_x, r_y, r_z}, v0); end
        checks++; if (lat != 3) begin errors++; $display("FAIL zero_latency: got %0d want 3", lat); end
        consume();
        start_cmd(v0, 1'b1, 1'b0, 63, sh0, ld0);
        ref_run(v0, 1'b1, 1'b0, MAXI, 0, ev, ne);
        checks++; if (r_done != 32) begin errors++; $display("FAIL clamp_iter_done: got %0d want 32", r_done); end
        checks++; if (lat != 35) begin errors++; $display("FAIL clamp_latency: got %0d want 35", lat); end
        checks++; if ({r_x, r_y, r_z} !== ev) begin errors++; $display("FAIL clamp_ref: got %h want %h", {r_x, r_y, r_z}, ev); end
        consume();
    endtask

    task automatic test_backpressure();
        vec_t v0; int sh0, ld0; logic [3*W-1:0] held;
        v0.x = 32'sh18000000; v0.y = 32'sh02000000; v0.z = -32'sh10000000; ovf_at = 0;
        start_cmd(v0, 1'b1, 1'b1, 4, sh0, ld0);
        held = {r_x, r_y, r_z};
        for (int i = 0; i < 5; i++) begin
            bus.cmd_valid = 1'b1; bus.cmd_iter = IW'(9);
            @(negedge clk);
            checks++; if ({bus.res_x, bus.res_y, bus.res_z} !== held || bus.res_valid !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: res_valid=%b res_x=%h want 1 / %h", i, bus.res_valid, bus.res_x, held[3*W-1:2*W]); end
            checks++; if (bus.cmd_ready !== 1'b0) begin errors++; $display("FAIL bp_cmd_ready[%0d]: got %b want 0", i, bus.cmd_ready); end
        end
        bus.cmd_valid = 1'b0;
        checks++; if (n_load - ld0 != 1) begin errors++; $display("FAIL bp_no_accept: loads=%0d want 1", n_load - ld0); end
        consume();
        checks++; if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release: cmd_ready=%b res_valid=%b want 1/0", bus.cmd_ready, bus.res_valid); end
        start_cmd(v0, 1'b0, 1'b0, 7, sh0, ld0);
        checks++; if (lat != 10 || r_done != 7) begin errors++; $display("FAIL bp_next: lat=%0d done=%0d want 10/7", lat, r_done); end
        consume();
    endtask

    task automatic test_reset_abort();
        vec_t v0, ev; int sh0, ld0, ne, seen;
        v0.x = 32'sh0C000000; v0.y = 32'sh03000000; v0.z = 32'sh05000000; ovf_at = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_x = v0.x; bus.cmd_y = v0.y; bus.cmd_z = v0.z;
        bus.cmd_system = 1'b1; bus.cmd_mode = 1'b1; bus.cmd_iter = IW'(10);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (core_enable !== 1'b1) begin errors++; $display("FAIL abort_in_iter: core_enable=%b want 1", core_enable); end
        rst = 1'b1;
        #1;
        checks++; if (core_enable !== 1'b0 || core_load !== 1'b0) begin
            errors++; $display("FAIL abort_same_cycle: enable=%b load=%b want 0/0", core_enable, core_load); end
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.cmd_ready !== 1'b1 || busy !== 1'b0 || bus.res_valid !== 1'b0) begin
            errors++; $display("FAIL abort_idle: cmd_ready=%b busy=%b res_valid=%b want 1/0/0", bus.cmd_ready, busy, bus.res_valid); end
        checks++; if ({core_shift, core_x_init, core_system, bus.res_x, bus.res_iter_done, bus.res_overflow} !== '0) begin
            errors++; $display("FAIL abort_outputs: shift=%0d res_x=%h want 0", core_shift, bus.res_x); end
        seen = 0;
        repeat (15) begin @(negedge clk); if (bus.res_valid) seen++; end
        checks++; if (seen != 0) begin errors++; $display("FAIL abort_no_result: res_valid cycles=%0d want 0", seen); end
        start_cmd(v0, 1'b1, 1'b1, 6, sh0, ld0);
        ref_run(v0, 1'b1, 1'b1, 6, 0, ev, ne);
        checks++; if ({r_x, r_y, r_z} !== ev || lat != 9) begin
            errors++; $display("FAIL abort_recover: got %h lat=%0d want %h lat=9", {r_x, r_y, r_z}, lat, ev); end
        consume();
    endtask

    task automatic test_random();
        vec_t v0, ev; int sh0, ld0, ne, iter, n; logic circ, rot; bit shifts_ok;
        for (int t = 0; t < 24; t++) begin
            v0.x = $signed($urandom) >>> 3; v0.y = $signed($urandom) >>> 3; v0.z = $urandom;
            circ = 1'($urandom_range(0, 1)); rot = 1'($urandom_range(0, 1));
            iter = $urandom_range(0, 40);
            ovf_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 12) : 0;
            n = (iter > MAXI) ? MAXI : iter;
            start_cmd(v0, circ, rot, iter, sh0, ld0);
            ref_run(v0, circ, rot, n, ovf_at, ev, ne);
            checks++; if (lat != ne + 3) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", t, lat, ne + 3); end
            checks++; if (r_done != ne) begin errors++; $display("FAIL rnd%0d_iter_done: got %0d want %0d", t, r_done, ne); end
            checks++; if (r_ovf !== 1'(ovf_at > 0 && ovf_at <= n)) begin
                errors++; $display("FAIL rnd%0d_ovf: got %b want %b", t, r_ovf, (ovf_at > 0 && ovf_at <= n)); end
            checks++; if ({r_x, r_y, r_z} !== ev) begin errors++; $display("FAIL rnd%0d_result: got %h want %h", t, {r_x, r_y, r_z}, ev); end
            shifts_ok = (obs_shift.size() - sh0 == ne);
            for (int i = 0; i < ne && shifts_ok; i++) shifts_ok = (obs_shift[sh0 + i] == exp_q[i]);
            checks++; if (!shifts_ok) begin errors++; $display("FAIL rnd%0d_shifts: observed %0d enables, want %0d with reference sequence", t, obs_shift.size() - sh0, ne); end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            consume();
        end
        ovf_at = 0;
    endtask

    initial begin
        init_tables();
        test_reset();
        test_circular_rotation();
        test_shift_seq();
        test_overflow();
        test_zero_and_clamp();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cordic_controller.md
Name: cordic_controller

Overview:
- Hardware sequencer that sits directly upstream of the `cordic` core and replaces the bench-side sequencer in synthesised designs.
- Accepts a command (initial x/y/z, rotation system, control mode, iteration count) over a valid/ready handshake.
- Loads the core, then issues one iteration per cycle with the correct shift index, including the hyperbolic repeats.
- Stops early on core overflow and returns the final x/y/z and status over a second valid/ready handshake.

Parameters:
- p_WIDTH, 32: data width of x, y, z. x and y use the core's Q-format; z is a binary angle with 2^p_WIDTH = 360 deg.
- p_MAX_ITER, 32: maximum iterations per command; larger requests are clamped.
- p_ITER_W, $clog2(p_MAX_ITER+1): width of iteration counts.
- p_SHIFT_W, $clog2(p_WIDTH): width of the shift index sent to the core.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept.
- cmd_x, cmd_y, cmd_z  in  p_WIDTH  initial values.
- cmd_system  in  1  1 = circular, 0 = hyperbolic.
- cmd_mode  in  1  1 = rotation, 0 = vectoring.
- cmd_iter  in  p_ITER_W  requested iteration count.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_x, res_y, res_z  out  p_WIDTH  final core state.
- res_overflow  out  1  run terminated by core overflow.
- res_iter_done  out  p_ITER_W  iterations actually performed, including the overflowing one.
- busy  out  1  high in every state except IDLE.
- core_load  out  1  one-cycle load strobe.
- core_x_init, core_y_init, core_z_init  out  p_WIDTH  load operands.
- core_system, core_mode  out  1  held stable from LOAD through FINISH.
- core_enable  out  1  perform one iteration at this edge.
- core_shift  out  p_SHIFT_W  shift index for the current iteration.
- core_x, core_y, core_z  in  p_WIDTH  core registered state.
- core_overflow  in  1  combinational flag: the iteration now enabled overflows.

Behaviour:
- Reset values: all outputs 0, except cmd_ready = 1. State = IDLE.
- rst during any state aborts the run: the result is discarded and core_load/core_enable drop in the same cycle.
- States:
  - IDLE: cmd_ready = 1. On cmd_valid, latch the command, with the count clamped to min(cmd_iter, p_MAX_ITER). Go to LOAD.
  - LOAD: exactly one cycle. core_load = 1, operands driven from latched registers. Go to ITER if count > 0, else FINISH.
  - ITER: core_enable = 1 every cycle. iter_cnt increments at each edge.
    - Overflow takes priority over normal completion. If core_overflow = 1 at an edge, set ovf, then go to FINISH.
    - Otherwise go to FINISH when iter_cnt + 1 == count.
  - FINISH: one cycle. Capture core_x/y/z into res_* and iter_cnt into res_iter_done. Go to DONE.
  - DONE: res_valid = 1. Outputs are stable while res_ready = 0. On res_ready, go to IDLE.
- No same-cycle re-accept: cmd_ready first rises the cycle after the result is consumed.
- Latency: command accepted at edge 0 gives res_valid high in cycle N+3 (N = clamped count). Minimum 3 cycles when N = 0.
- Shift sequence:
  - Circular: 0, 1, 2, …
  - Hyperbolic: starts at 1; indices 4, 13 and 40 are each issued twice.
  - Each repeat counts as one iteration.
  - The index saturates at p_WIDTH-1.
- res_overflow and res_iter_done are cleared on each new command accept.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- cordic_pkg holds:
  - the state enum (IDLE, LOAD, ITER, FINISH, DONE);
  - the hyperbolic repeat constants 4, 13, 40;
  - the 360-deg-per-2^WIDTH angle scale constant.
- Sub-module cordic_shift_gen:
  - counter with clear/advance inputs and a system select;
  - produces core_shift, including the repeat-flag logic.

Test Plan:
- Circular rotation, x = 0x4DBA76D4 (0.60725), y = 0, z = 0x20000000 (45 deg), N = 10 → res_valid in cycle 13; res_x ≈ res_y ≈ 0.7071 ±2^-9; res_z ≈ 0 ±0.12 deg; res_overflow = 0; res_iter_done = 10.
- Hyperbolic, N = 16 → core_shift across ITER cycles is exactly 1,2,3,4,4,5,6,7,8,9,10,11,12,13,13,14. Circular N = 5 → 0,1,2,3,4.
- Model asserts core_overflow on the 3rd enabled cycle, N = 10 → ITER lasts 3 cycles; res_overflow = 1; res_iter_done = 3.
- cmd_iter = 0 → one core_load, no core_enable; res_x/y/z equal the initial values; res_valid in cycle 3. cmd_iter = 63 → clamped, res_iter_done = 32.
- Hold res_ready low 5 cycles → res_* stable, cmd_ready = 0, and a cmd_valid offered meanwhile is not accepted. Release → IDLE, then the next command is accepted.
- rst pulsed in the 4th ITER cycle → next cycle: IDLE, all outputs 0, cmd_ready = 1, no res_valid. A following command completes normally.
